// File: rtl/config_loader.sv
// Byte-serial configuration loader: validates SYNC/B1/B2/CHK frames and commits sel1..sel4/C_external.
// Optional macro CFG_LOCK_EN: after the first commit the loader locks until RST.
module config_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] CHK_SEED  = 8'h5A,
    parameter int         TIMEOUT   = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] sel1,
    output logic [1:0] sel2,
    output logic [1:0] sel3,
    output logic [1:0] sel4,
    output logic       C_external,
    output logic       cfg_done,
    output logic       cfg_load,
    output logic       cfg_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    // Handshake: a byte moves on a rising CLK edge where din_valid && din_ready;
    // din_ready depends only on state, never on din_valid.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_B1  = 3'd1,
        GET_B2  = 3'd2,
        GET_CHK = 3'd3,
        HOLD    = 3'd4,
        LOCKED  = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [7:0]    shadow_b1, shadow_b1_next;
    logic          shadow_c, shadow_c_next;
    logic [7:0]    cfg_sel;
    logic          cfg_c;
    logic          xfer;
    logic          commit;
    logic          err;
    logic [7:0]    chk_expected;

    assign din_ready    = (state != HOLD);
    assign xfer         = din_valid && din_ready;
    assign chk_expected = shadow_b1 ^ {7'b0, shadow_c} ^ CHK_SEED;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        shadow_b1_next = shadow_b1;
        shadow_c_next  = shadow_c;
        commit         = 1'b0;
        err            = 1'b0;
        case (state)
            IDLE: begin
                // Non-sync bytes are dropped here without raising an error.
                if (xfer && din == SYNC_BYTE) begin
                    state_next = GET_B1;
                    cnt_next   = '0;
                end
            end
            GET_B1, GET_B2, GET_CHK: begin
                if (xfer) begin
                    cnt_next = '0;
                    if (state == GET_B1) begin
                        shadow_b1_next = din;
                        state_next     = GET_B2;
                    end else if (state == GET_B2) begin
                        if (din[7:1] != 7'd0) begin
                            err        = 1'b1;
                            state_next = IDLE;
                        end else begin
                            shadow_c_next = din[0];
                            state_next    = GET_CHK;
                        end
                    end else if (din == chk_expected) begin
                        commit     = 1'b1;
                        state_next = HOLD;
                    end else begin
                        err        = 1'b1;
                        state_next = IDLE;
                    end
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    // This idle cycle makes the gap TIMEOUT long: abandon the frame.
                    err        = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HOLD: begin
`ifdef CFG_LOCK_EN
                state_next = LOCKED;
`else
                state_next = IDLE;
`endif
            end
`ifdef CFG_LOCK_EN
            LOCKED: begin
                state_next = LOCKED;
            end
`endif
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow_b1 <= 8'd0;
            shadow_c  <= 1'b0;
            cfg_sel   <= 8'd0;
            cfg_c     <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_load  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            shadow_b1 <= shadow_b1_next;
            shadow_c  <= shadow_c_next;
            cfg_load  <= commit;
            cfg_err   <= err;
            if (commit) begin
                cfg_sel  <= shadow_b1;
                cfg_c    <= shadow_c;
                cfg_done <= 1'b1;
            end
        end
    end

    assign sel1       = cfg_sel[1:0];
    assign sel2       = cfg_sel[3:2];
    assign sel3       = cfg_sel[5:4];
    assign sel4       = cfg_sel[7:6];
    assign C_external = cfg_c;

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Upstream configuration stage for config_fpga.
- Accepts a byte-serial configuration frame over a valid/ready handshake, checks its framing and checksum, and only then drives sel1..sel4 and C_external into the fabric.
- Bad or truncated frames never disturb the committed configuration.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- CHK_SEED, 8'h5A, checksum seed.
- TIMEOUT, 16, max idle cycles between bytes inside a frame before abort (min 2).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- din  input  8  configuration byte.
- din_valid  input  1  din holds a byte.
- din_ready  output  1  loader can accept a byte this cycle.
- sel1  output  2  committed select, CLB1.
- sel2  output  2  committed select, CLB2.
- sel3  output  2  committed select, CLB3.
- sel4  output  2  committed select, CLB4.
- C_external  output  1  committed external carry-in.
- cfg_done  output  1  sticky: at least one frame committed since reset.
- cfg_load  output  1  1-cycle pulse on commit.
- cfg_err  output  1  1-cycle pulse on frame rejection.

Behaviour:
- Single clock CLK. Reset is synchronous and active-high on RST.
- Reset values: all outputs 0, except din_ready = 1. State = IDLE, timeout counter = 0.
- RST mid-frame discards the partial frame and clears committed config.
- A byte transfers on a rising edge where din_valid && din_ready.
- Frame format: SYNC_BYTE, B1 = {sel4,sel3,sel2,sel1}, B2 = {7'b0, C_external}, CHK = B1 ^ B2 ^ CHK_SEED.
- FSM states: IDLE, GET_B1, GET_B2, GET_CHK, HOLD.
- IDLE: transfer of SYNC_BYTE -> GET_B1. Any other byte is consumed silently, no error.
- GET_B1: transfer -> capture into shadow register, go to GET_B2.
- GET_B2: transfer -> capture, go to GET_CHK. Reserved bits B2[7:1] != 0 -> cfg_err, IDLE.
- GET_CHK: transfer with matching CHK -> commit shadow to outputs on the same edge, cfg_load = 1 and cfg_done = 1 next cycle, go to HOLD. Mismatch -> cfg_err, outputs unchanged, IDLE.
- HOLD: exactly one cycle with din_ready = 0, then IDLE.
- din_ready is 1 in every state except HOLD.
- Latency: committed values are visible in the cycle after the CHK transfer.
- Timeout: in GET_B1, GET_B2 or GET_CHK the counter increments on each cycle with no transfer and clears on every transfer.
  - Counter reaching TIMEOUT -> cfg_err, IDLE, counter cleared.
  - The counter is not active in IDLE or HOLD.
- A SYNC_BYTE value received mid-frame is treated as data, not as a resync.
- Shadow registers are never visible on outputs until commit.
- Only one cfg_err pulse per rejected frame. cfg_err and cfg_load are never high together.

Optional Feature:
- Macro: CFG_LOCK_EN.
- Defined: after the first successful commit the loader enters LOCKED permanently, until RST.
  - din_ready stays 1 and all bytes are consumed and ignored.
  - No cfg_load or cfg_err is generated; outputs are frozen.
- Undefined: after HOLD the FSM returns to IDLE, and any later valid frame recommits (reconfiguration allowed).

Test Plan:
1. Reset then frame A5,39,01,62 at 1 byte/cycle -> cycle after 62 transfer: sel1=01, sel2=10, sel3=11, sel4=00, C_external=1, cfg_load 1-cycle pulse, cfg_done=1; din_ready=0 for one cycle.
2. Frame A5,39,01,63 -> cfg_err pulse; all selects and C_external stay 0; cfg_done=0. A following good frame then commits.
3. Bytes 00,FF,A5,0F,00,55 (CHK = 0F^00^5A = 55) -> leading junk ignored with no error; sel1=11, sel2=11, sel3=00, sel4=00, C_external=0 committed.
4. A5,39, then din_valid low for 16 cycles -> cfg_err at timeout. A subsequent A5,39,01,62 commits normally.
5. A5,39,03,... (reserved bit set) -> cfg_err on B2 transfer, no commit. Also: RST asserted after B2 -> all outputs 0, and the next frame starts from IDLE.
6. After a good commit, send A5,00,00,5A.
   - Without CFG_LOCK_EN: selects go to 00, C_external to 0.
   - With CFG_LOCK_EN: outputs keep the earlier values, and no cfg_load or cfg_err pulses.
